// File: rtl/parity_stream_codec_pkg.sv
// Shared constants for the parity stream codec: parity sense encodings, default widths
// and the codeword-width helper (payload plus one parity bit in the MSB).
package parity_stream_codec_pkg;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    localparam int DEFAULT_DATA_W    = 8;
    localparam int DEFAULT_ERR_CNT_W = 8;

    function automatic int code_w(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/parity_stream_codec_parity_calc.sv
// Combinational parity over W bits; odd_mode inverts the result so the same block
// serves as both generator and checker.
module parity_calc
    import parity_stream_codec_pkg::*;
#(
    parameter int W = DEFAULT_DATA_W
) (
    input  logic [W-1:0] data,
    input  logic         odd_mode,
    output logic         parity
);

    assign parity = (^data) ^ (odd_mode == PARITY_ODD);

endmodule

// File: rtl/parity_stream_codec.sv
// Two-stage parity encode / channel-noise / check pipeline with valid-ready on both sides,
// plus a saturating error counter and sticky error flag updated on delivered words.
module parity_stream_codec
    import parity_stream_codec_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int ERR_CNT_W = DEFAULT_ERR_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_W-1:0]    in_data,
    input  logic                 odd_mode,
    input  logic [DATA_W:0]      inj_mask,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data,
    output logic                 out_parity,
    output logic                 out_err,
    input  logic                 clr_err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 err_sticky
);

    localparam int CODE_W = code_w(DATA_W);

    logic              s1_valid;
    logic [CODE_W-1:0] s1_code;
    logic              s1_odd;

    logic gen_parity;
    logic chk_err;
    logic s2_load_ok;
    logic s1_load_ok;
    logic out_fire;

    parity_calc #(.W(DATA_W)) u_gen (
        .data     (in_data),
        .odd_mode (odd_mode),
        .parity   (gen_parity)
    );

    // Re-computing parity over the whole received codeword yields zero when it is intact.
    parity_calc #(.W(CODE_W)) u_chk (
        .data     (s1_code),
        .odd_mode (s1_odd),
        .parity   (chk_err)
    );

    assign s2_load_ok = !out_valid || out_ready;
    assign s1_load_ok = !s1_valid || s2_load_ok;
    assign in_ready   = s1_load_ok;
    assign out_fire   = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_code  <= '0;
            s1_odd   <= 1'b0;
        end else if (s1_load_ok) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_code <= {gen_parity, in_data} ^ inj_mask;
                s1_odd  <= odd_mode;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_parity <= 1'b0;
            out_err    <= 1'b0;
        end else if (s2_load_ok) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data   <= s1_code[DATA_W-1:0];
                out_parity <= s1_code[DATA_W];
                out_err    <= chk_err;
            end
        end
    end

    // A clear coinciding with an errored delivery restarts the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end else if (out_fire && out_err) begin
            err_sticky <= 1'b1;
            if (clr_err) begin
                err_count <= ERR_CNT_W'(1);
            end else if (!(&err_count)) begin
                err_count <= err_count + ERR_CNT_W'(1);
            end
        end else if (clr_err) begin
            err_count  <= '0;
            err_sticky <= 1'b0;
        end
    end

endmodule
